// File: rtl/loop_pd_arb.sv
// loop_pd_arb: packet-granular arbiter sharing the rxm packet write FIFO
// between the loopback scheduler (source 0) and a second datapath (source 1).
//
// Ports:
//   clk_sys, rst            system clock, asynchronous active-high reset
//   srcN_rd                 pop strobe to source N FIFO (combinational)
//   srcN_rdata, srcN_emp    show-ahead head word and empty flag of source N
//   sch2rxm_pd_wr/_wdata    registered write strobe and data to the rxm FIFO
//   rxm2sch_pd_ff           rxm FIFO full (leaves 2 entries of slack)
//   reg_arb_mode            0 = round-robin, 1 = strict priority to source 0
//   cnt_reg_clr             synchronous clear of counters and error flags
//   reg_pkt_cnt0/1          packets forwarded per source
//   reg_len_err             sticky oversize-packet flag per source
//   reg_arb_sta             FSM state for debug
module loop_pd_arb #(
  parameter int unsigned DW        = 540,
  parameter int unsigned EOP_BIT   = 539,
  parameter int unsigned MAX_BEATS = 64,
  parameter int unsigned CW        = 32
) (
  input  logic          clk_sys,
  input  logic          rst,
  output logic          src0_rd,
  input  logic [DW-1:0] src0_rdata,
  input  logic          src0_emp,
  output logic          src1_rd,
  input  logic [DW-1:0] src1_rdata,
  input  logic          src1_emp,
  output logic          sch2rxm_pd_wr,
  output logic [DW-1:0] sch2rxm_pd_wdata,
  input  logic          rxm2sch_pd_ff,
  input  logic          reg_arb_mode,
  input  logic          cnt_reg_clr,
  output logic [CW-1:0] reg_pkt_cnt0,
  output logic [CW-1:0] reg_pkt_cnt1,
  output logic [1:0]    reg_len_err,
  output logic [1:0]    reg_arb_sta
);

  // Beat counter must hold MAX_BEATS+1 (saturation value).
  localparam int unsigned BW = $clog2(MAX_BEATS + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2
  } state_e;

  state_e        state, state_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic [BW-1:0] beat_cnt, beat_cnt_nxt;
  logic          pop;
  logic          pop_src;
  logic          pop_eop;
  logic [DW-1:0] pop_data;

  // Grant decision, pop generation and packet tracking.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    beat_cnt_nxt = beat_cnt;
    src0_rd      = 1'b0;
    src1_rd      = 1'b0;

    case (state)
      IDLE: begin
        if (reg_arb_mode) begin
          if (!src0_emp)      state_nxt = XFER0;
          else if (!src1_emp) state_nxt = XFER1;
        end else begin
          // Round-robin: with both pending, the source not granted last wins.
          if (!src0_emp && !src1_emp) state_nxt = last_gnt ? XFER0 : XFER1;
          else if (!src0_emp)         state_nxt = XFER0;
          else if (!src1_emp)         state_nxt = XFER1;
        end
      end
      XFER0:   src0_rd = !src0_emp && !rxm2sch_pd_ff;
      XFER1:   src1_rd = !src1_emp && !rxm2sch_pd_ff;
      default: state_nxt = IDLE;
    endcase

    pop      = src0_rd | src1_rd;
    pop_src  = src1_rd;
    pop_data = src1_rd ? src1_rdata : src0_rdata;
    pop_eop  = pop_data[EOP_BIT];

    if (pop) begin
      if (pop_eop) begin
        state_nxt    = IDLE;
        last_gnt_nxt = pop_src;
        beat_cnt_nxt = '0;
      end else if (beat_cnt != BW'(MAX_BEATS + 1)) begin
        beat_cnt_nxt = beat_cnt + BW'(1);
      end
    end
  end

  // FSM state, last-grant pointer and beat counter.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // One-stage output pipeline; wdata holds between writes.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sch2rxm_pd_wr    <= 1'b0;
      sch2rxm_pd_wdata <= '0;
    end else begin
      sch2rxm_pd_wr <= pop;
      if (pop) sch2rxm_pd_wdata <= pop_data;
    end
  end

  // Statistics: counters step with the EOP write; clear dominates.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      reg_pkt_cnt0 <= '0;
      reg_pkt_cnt1 <= '0;
      reg_len_err  <= '0;
    end else if (cnt_reg_clr) begin
      reg_pkt_cnt0 <= '0;
      reg_pkt_cnt1 <= '0;
      reg_len_err  <= '0;
    end else begin
      if (pop && pop_eop && !pop_src) reg_pkt_cnt0 <= reg_pkt_cnt0 + CW'(1);
      if (pop && pop_eop &&  pop_src) reg_pkt_cnt1 <= reg_pkt_cnt1 + CW'(1);
      // beat_cnt holds beats already popped, so this pop is beat MAX_BEATS+1.
      if (pop && !pop_eop && (beat_cnt == BW'(MAX_BEATS))) reg_len_err[pop_src] <= 1'b1;
    end
  end

  assign reg_arb_sta = state;

endmodule
